// File: rtl/fifo_pkg.sv
// Shared helpers for the asynchronous FIFO pointer blocks: Gray/binary
// conversion and depth derivation, reused by both the write and read sides.
package fifo_pkg;

  localparam int DEFAULT_ADDR_SIZE = 3;

  function automatic int fifo_depth(input int addr_size);
    return 1 << addr_size;
  endfunction

  // Operands are zero-extended to 32 bits; callers size-cast the result back
  // to their own pointer width, so a single definition serves every width.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/sync_r2w.sv
// Generic two-flop synchroniser carrying a Gray-coded pointer into the local
// clock domain; both stages clear on synchronous reset.
module sync_r2w #(
  parameter int width = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [width-1:0] d,
  output logic [width-1:0] q
);

  logic [width-1:0] stage_p0;

  // stage p0: metastability catch; stage p1: settled output
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_p0 <= '0;
      q        <= '0;
    end else begin
      stage_p0 <= d;
      q        <= stage_p0;
    end
  end

endmodule

// File: rtl/write_ptr_full.sv
// Write-side pointer and status generation for the asynchronous FIFO:
// binary/Gray write pointer, synchronised read pointer, full/almost-full/count/overflow.
module write_ptr_full
  import fifo_pkg::*;
#(
  parameter int address_Size      = DEFAULT_ADDR_SIZE,
  parameter int almost_Full_Level = 6
) (
  input  logic                  w_Clk,
  input  logic                  w_Rst,
  input  logic                  w_Inc,
  input  logic [address_Size:0] r_Ptr_Gray,
  output logic [address_Size-1:0] w_Addr,
  output logic [address_Size:0] w_Ptr_Gray,
  output logic                  fifo_Full,
  output logic                  fifo_Almost_Full,
  output logic [address_Size:0] w_Count,
  output logic                  w_Overflow
);

  localparam int PW = address_Size + 1;
  localparam logic [PW-1:0] AF_LEVEL = PW'(almost_Full_Level);

  logic [PW-1:0] rq2;
  logic [PW-1:0] wbin;
  logic [PW-1:0] wbin_next;
  logic [PW-1:0] wgray_next;
  logic [PW-1:0] rbin_s;
  logic [PW-1:0] count_next;
  logic          accept;
  logic          full_next;
  logic          afull_next;

  sync_r2w #(.width(PW)) u_sync_r2w (
    .clk (w_Clk),
    .rst (w_Rst),
    .d   (r_Ptr_Gray),
    .q   (rq2)
  );

  assign accept     = w_Inc & ~fifo_Full;
  assign wbin_next  = wbin + PW'(accept);
  assign wgray_next = PW'(bin2gray(32'(wbin_next)));
  assign rbin_s     = PW'(gray2bin(32'(rq2)));

  // Full when the write pointer has lapped the read pointer by exactly one
  // depth: in Gray code that is the top two bits inverted, the rest equal.
  assign full_next  = (wgray_next == {~rq2[PW-1:PW-2], rq2[PW-3:0]});
  assign count_next = wbin_next - rbin_s;
  assign afull_next = (count_next >= AF_LEVEL);

  assign w_Addr = wbin[address_Size-1:0];

  // stage p0: pointer and status registers, all updated from the same next-state
  always_ff @(posedge w_Clk) begin
    if (w_Rst) begin
      wbin             <= '0;
      w_Ptr_Gray       <= '0;
      fifo_Full        <= 1'b0;
      fifo_Almost_Full <= 1'b0;
      w_Count          <= '0;
      w_Overflow       <= 1'b0;
    end else begin
      wbin             <= wbin_next;
      w_Ptr_Gray       <= wgray_next;
      fifo_Full        <= full_next;
      fifo_Almost_Full <= afull_next;
      w_Count          <= count_next;
      w_Overflow       <= w_Overflow | (w_Inc & fifo_Full);
    end
  end

endmodule
